// File: rtl/wb_master.sv
// Single-outstanding Wishbone B4 classic master: one local command becomes one bus cycle.
// Optional feature macro: WB_MASTER_TIMEOUT_EN adds a bus-cycle timeout that returns rsp_err_o.
module wb_master #(
   parameter int ADR_WIDTH = 4,
   parameter int WIDTH     = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                 wb_clk_in,
   input  logic                 wb_rst_in,
   input  logic                 cmd_valid_in,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_in,
   input  logic [ADR_WIDTH-1:0] cmd_adr_in,
   input  logic [WIDTH-1:0]     cmd_dat_in,
   output logic                 rsp_valid_o,
   output logic [WIDTH-1:0]     rsp_dat_o,
   output logic                 rsp_err_o,
   output logic [ADR_WIDTH-1:0] wb_adr_o,
   output logic [WIDTH-1:0]     wb_dat_o,
   output logic                 wb_we_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   input  logic                 wb_ack_in,
   input  logic [WIDTH-1:0]     wb_dat_in
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_cmdReady;
   logic                   r_rspValid;
   logic [WIDTH-1:0]       r_rspDat;
   logic [ADR_WIDTH-1:0]   r_wbAdr;
   logic [WIDTH-1:0]       r_wbDat;
   logic                   r_wbWe;
   logic                   r_wbCyc;
   logic                   r_wbStb;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]       r_toCount;
   logic                   r_rspErr;
`endif

   // RESP always inserts one STB-low cycle so a registered-ACK slave can drop ACK.
   always_ff @(posedge wb_clk_in) begin
      if (wb_rst_in) begin
         r_state    <= ST_IDLE;
         r_cmdReady <= 1'b1;
         r_rspValid <= 1'b0;
         r_rspDat   <= '0;
         r_wbAdr    <= '0;
         r_wbDat    <= '0;
         r_wbWe     <= 1'b0;
         r_wbCyc    <= 1'b0;
         r_wbStb    <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
         r_toCount  <= '0;
         r_rspErr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rspValid <= 1'b0;
               if (cmd_valid_in) begin
                  r_wbWe     <= cmd_we_in;
                  r_wbAdr    <= cmd_adr_in;
                  r_wbDat    <= cmd_dat_in;
                  r_wbCyc    <= 1'b1;
                  r_wbStb    <= 1'b1;
                  r_cmdReady <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                  r_toCount  <= '0;
`endif
                  r_state    <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (wb_ack_in) begin
                  r_wbCyc    <= 1'b0;
                  r_wbStb    <= 1'b0;
                  r_rspValid <= 1'b1;
                  if (!r_wbWe) begin
                     r_rspDat <= wb_dat_in;
                  end
`ifdef WB_MASTER_TIMEOUT_EN
                  r_rspErr   <= 1'b0;
`endif
                  r_state    <= ST_RESP;
               end
`ifdef WB_MASTER_TIMEOUT_EN
               // The count reaching TIMEOUT on this edge means STB was high for TIMEOUT cycles.
               else if (r_toCount == CNT_W'(TIMEOUT - 1)) begin
                  r_wbCyc    <= 1'b0;
                  r_wbStb    <= 1'b0;
                  r_rspValid <= 1'b1;
                  r_rspErr   <= 1'b1;
                  r_rspDat   <= '0;
                  r_toCount  <= CNT_W'(TIMEOUT);
                  r_state    <= ST_RESP;
               end else begin
                  r_toCount  <= r_toCount + CNT_W'(1);
               end
`endif
            end
            ST_RESP: begin
               r_rspValid <= 1'b0;
               r_cmdReady <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_rspValid <= 1'b0;
               r_cmdReady <= 1'b1;
               r_wbCyc    <= 1'b0;
               r_wbStb    <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = r_cmdReady;
   assign rsp_valid_o = r_rspValid;
   assign rsp_dat_o   = r_rspDat;
   assign wb_adr_o    = r_wbAdr;
   assign wb_dat_o    = r_wbDat;
   assign wb_we_o     = r_wbWe;
   assign wb_cyc_o    = r_wbCyc;
   assign wb_stb_o    = r_wbStb;

`ifdef WB_MASTER_TIMEOUT_EN
   assign rsp_err_o   = r_rspErr;
`else
   assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: directed and random transfers against a memory-level model.
// Define WB_MASTER_TIMEOUT_EN at build time to also exercise the timeout path with TIMEOUT=8.
module tb_wb_master;

   localparam int AW = 4;
   localparam int DW = 8;
`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cmdValid;
   logic          cmd_ready_o;
   logic          cmdWe;
   logic [AW-1:0] cmdAdr;
   logic [DW-1:0] cmdDat;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_dat_o;
   logic          rsp_err_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          slvAck;
   logic [DW-1:0] slvDat;

   int checks = 0;
   int errors = 0;

   wb_master #(.ADR_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
      .wb_clk_in    (clk),
      .wb_rst_in    (rst),
      .cmd_valid_in (cmdValid),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_we_in    (cmdWe),
      .cmd_adr_in   (cmdAdr),
      .cmd_dat_in   (cmdDat),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_dat_o    (rsp_dat_o),
      .rsp_err_o    (rsp_err_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_we_o      (wb_we_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_ack_in    (slvAck),
      .wb_dat_in    (slvDat)
   );

   always #5 clk = ~clk;

   // Slave: registered ACK after slvDelay cycles of STB (1 behaves like dp_ram); 0 never ACKs.
   logic [DW-1:0] slvMem [16] = '{default: '0};
   int            slvDelay = 1;
   int            slvWait  = 0;

   always @(posedge clk) begin
      if (rst) begin
         slvAck  <= 1'b0;
         slvWait <= 0;
      end else if (wb_cyc_o && wb_stb_o && !slvAck && slvDelay > 0) begin
         if (slvWait >= slvDelay - 1) begin
            slvAck  <= 1'b1;
            slvWait <= 0;
            if (wb_we_o) begin
               slvMem[wb_adr_o] <= wb_dat_o;
               slvDat           <= DW'($urandom);
            end else begin
               slvDat <= slvMem[wb_adr_o];
            end
         end else begin
            slvWait <= slvWait + 1;
         end
      end else begin
         slvAck <= 1'b0;
      end
   end

   // Reference: what the client should see, in terms of memory contents and the last response.
   logic [DW-1:0] refMem [16] = '{default: '0};
   logic [DW-1:0] expRspDat   = '0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer, called and returning at a falling edge.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                input int delay, input string tag);
      int   stbCycles = 0;
      int   guard     = 0;
      logic stableBad = 1'b0;
      while (!cmd_ready_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({tag, ".ready"}, 32'(cmd_ready_o), 32'd1);
      slvDelay = delay;
      cmdValid = 1'b1;
      cmdWe    = we;
      cmdAdr   = adr;
      cmdDat   = dat;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      cmdWe    = ~we;
      cmdAdr   = AW'($urandom);
      cmdDat   = DW'($urandom);
      if (we) refMem[adr] = dat;
      else expRspDat = refMem[adr];
      @(negedge clk);
      checkOutput({tag, ".cyc"}, 32'(wb_cyc_o), 32'd1);
      checkOutput({tag, ".busy"}, 32'(cmd_ready_o), 32'd0);
      guard = 0;
      while (wb_cyc_o && guard < 100) begin
         stbCycles++;
         if (wb_adr_o !== adr || wb_we_o !== we || wb_dat_o !== dat || wb_stb_o !== 1'b1 ||
             rsp_valid_o !== 1'b0)
            stableBad = 1'b1;
         @(negedge clk);
         guard++;
      end
      checkOutput({tag, ".stable"}, 32'(stableBad), 32'd0);
      checkOutput({tag, ".stbCycles"}, 32'(stbCycles), 32'(delay + 1));
      checkOutput({tag, ".rspValid"}, 32'(rsp_valid_o), 32'd1);
      checkOutput({tag, ".rspErr"}, 32'(rsp_err_o), 32'd0);
      checkOutput({tag, ".rspDat"}, 32'(rsp_dat_o), 32'(expRspDat));
      checkOutput({tag, ".stbLow"}, 32'(wb_stb_o), 32'd0);
      @(negedge clk);
      checkOutput({tag, ".pulse"}, 32'(rsp_valid_o), 32'd0);
      checkOutput({tag, ".readyBack"}, 32'(cmd_ready_o), 32'd1);
   endtask

   initial begin
      int            accepted;
      int            responses;
      int            stbRises;
      int            stbCycles;
      logic          prevStb;
      logic          sawRsp;
      logic          willAccept;
      logic [DW-1:0] rspQ [$];

      rst      = 1'b1;
      cmdValid = 1'b0;
      cmdWe    = 1'b0;
      cmdAdr   = '0;
      cmdDat   = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset.ready", 32'(cmd_ready_o), 32'd1);
      checkOutput("reset.cyc", 32'(wb_cyc_o), 32'd0);
      checkOutput("reset.stb", 32'(wb_stb_o), 32'd0);
      checkOutput("reset.rspValid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset.rspDat", 32'(rsp_dat_o), 32'd0);
      checkOutput("reset.rspErr", 32'(rsp_err_o), 32'd0);
      checkOutput("reset.wbAdr", 32'(wb_adr_o), 32'd0);
      checkOutput("reset.wbDat", 32'(wb_dat_o), 32'd0);
      checkOutput("reset.wbWe", 32'(wb_we_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b1, 4'd3, 8'hA5, 1, "t1_wr");
      applyStimulus(1'b0, 4'd3, 8'h00, 1, "t2_rd");
      applyStimulus(1'b1, 4'd9, 8'h3C, 10, "t4_wr");
      applyStimulus(1'b0, 4'd9, 8'hFF, 10, "t4_rd");
      checkOutput("t4.rdVal", 32'(rsp_dat_o), 32'h3C);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(1, 4)),
                       $sformatf("rand%0d", i));
      end

      // Back-to-back: cmd_valid stays high, payload advances only after each acceptance.
      accepted  = 0;
      responses = 0;
      stbRises  = 0;
      prevStb   = 1'b0;
      slvDelay  = 1;
      cmdValid  = 1'b1;
      cmdWe     = 1'($urandom);
      cmdAdr    = AW'($urandom);
      cmdDat    = DW'($urandom);
      for (int c = 0; c < 60 && responses < 4; c++) begin
         if (wb_stb_o && !prevStb) stbRises++;
         prevStb = wb_stb_o;
         if (rsp_valid_o) begin
            responses++;
            if (rspQ.size() > 0) checkOutput($sformatf("b2b.rspDat%0d", responses),
                                             32'(rsp_dat_o), 32'(rspQ.pop_front()));
         end
         willAccept = cmdValid && cmd_ready_o;
         if (willAccept) begin
            accepted++;
            if (cmdWe) refMem[cmdAdr] = cmdDat;
            else expRspDat = refMem[cmdAdr];
            rspQ.push_back(expRspDat);
         end
         @(posedge clk);
         #1;
         if (willAccept) begin
            if (accepted == 4) cmdValid = 1'b0;
            cmdWe  = 1'($urandom);
            cmdAdr = AW'($urandom);
            cmdDat = DW'($urandom);
         end
         @(negedge clk);
      end
      cmdValid = 1'b0;
      checkOutput("b2b.accepted", 32'(accepted), 32'd4);
      checkOutput("b2b.responses", 32'(responses), 32'd4);
      checkOutput("b2b.stbRuns", 32'(stbRises), 32'd4);
      repeat (2) @(negedge clk);

`ifdef WB_MASTER_TIMEOUT_EN
      slvDelay = 0;
      cmdValid = 1'b1;
      cmdWe    = 1'b0;
      cmdAdr   = 4'd5;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      @(negedge clk);
      stbCycles = 0;
      for (int g = 0; g < 100 && wb_stb_o; g++) begin
         stbCycles++;
         @(negedge clk);
      end
      expRspDat = '0;
      checkOutput("t5.stbCycles", 32'(stbCycles), 32'(TO));
      checkOutput("t5.rspValid", 32'(rsp_valid_o), 32'd1);
      checkOutput("t5.rspErr", 32'(rsp_err_o), 32'd1);
      checkOutput("t5.rspDat", 32'(rsp_dat_o), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("t5.readyBack", 32'(cmd_ready_o), 32'd1);
`else
      stbCycles = 0;
`endif

      // Reset while a transfer is stuck in BUS.
      slvDelay = 0;
      cmdValid = 1'b1;
      cmdWe    = 1'b1;
      cmdAdr   = 4'd7;
      cmdDat   = 8'h81;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t6.inBus", 32'(wb_cyc_o), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6.cyc", 32'(wb_cyc_o), 32'd0);
      checkOutput("t6.stb", 32'(wb_stb_o), 32'd0);
      checkOutput("t6.ready", 32'(cmd_ready_o), 32'd1);
      checkOutput("t6.wbDat", 32'(wb_dat_o), 32'd0);
      sawRsp = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid_o) sawRsp = 1'b1;
         @(negedge clk);
      end
      checkOutput("t6.noRsp", 32'(sawRsp), 32'd0);
      checkOutput("t6.rspDat", 32'(rsp_dat_o), 32'd0);

      slvDelay = 1;
      applyStimulus(1'b0, 4'd3, 8'h00, 1, "t6_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
